// File: rtl/key_debouncer_pkg.sv
// Shared types and default timing for the keypad debouncer.
// The defaults assume a 48 MHz system clock.
package key_debouncer_pkg;

    // Debouncer control states. All four 2-bit encodings are in use.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } deb_state_t;

    // Default timing constants at 48 MHz.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 240_000;    // 5 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 24_000_000; // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = 4_800_000;  // 100 ms

    // Largest of three cycle counts. Used to size the shared timer.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/deb_timer.sv
// Saturating up-counter with synchronous clear and an equality hit flag.
// The debouncer shares a single instance between debounce and repeat timing.
module deb_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] target,
    output logic         hit
);

    localparam logic [W-1:0] COUNT_MAX = '1;

    logic [W-1:0] count;

    // Count up each cycle, stop at all-ones, restart from zero on clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != COUNT_MAX) begin
            // NOTE: non-blocking so every register in the design updates from
            // the same pre-edge values, whichever always_ff runs first.
            count <= count + 1'b1;
        end
    end

    assign hit = (count == target);

endmodule

// File: rtl/key_debouncer.sv
// Keypad debouncer: qualifies key_pressed plus code_in and emits one
// code_valid strobe per physical press, with held/released status.
// Optional auto-repeat while held is enabled by defining the macro
// KEY_DEBOUNCER_REPEAT_EN; without it no repeat logic is built.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned CODE_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_pressed,
    input  logic [CODE_W-1:0] code_in,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    output logic              key_held,
    output logic              key_released
);

    localparam int unsigned CNT_W =
        $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_DEBOUNCER_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    deb_state_t        state;
    logic [CODE_W-1:0] cand;
    logic              code_changed;
    logic              timer_clear;
    logic [CNT_W-1:0]  timer_target;
    logic              timer_hit;
`ifdef KEY_DEBOUNCER_REPEAT_EN
    logic              repeated;     // first repeat already issued this hold
`endif

    assign code_changed = (code_in != cand);

    deb_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .target (timer_target),
        .hit    (timer_hit)
    );

    // Timer control: clear on every state entry, window restart and repeat.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        timer_clear  = 1'b0;
        timer_target = DEB_LAST;
        case (state)
            IDLE:        timer_clear = 1'b1;
            DEB_PRESS:   timer_clear = !key_pressed || code_changed || timer_hit;
            HELD: begin
`ifdef KEY_DEBOUNCER_REPEAT_EN
                timer_target = repeated ? REP_PERIOD_LAST : REP_DELAY_LAST;
                timer_clear  = !key_pressed || timer_hit;
`else
                timer_clear  = !key_pressed;
`endif
            end
            DEB_RELEASE: timer_clear = key_pressed || timer_hit;
            default:     timer_clear = 1'b1;
        endcase
    end

    // Control FSM with registered strobes, status and accepted code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cand         <= '0;
            code_out     <= '0;
            code_valid   <= 1'b0;
            key_held     <= 1'b0;
            key_released <= 1'b0;
`ifdef KEY_DEBOUNCER_REPEAT_EN
            repeated     <= 1'b0;
`endif
        end else begin
            code_valid   <= 1'b0;
            key_released <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_pressed) begin
                        state <= DEB_PRESS;
                        cand  <= code_in;
                    end
                end
                DEB_PRESS: begin
                    // A dropout beats a code change, which beats acceptance.
                    if (!key_pressed) begin
                        state <= IDLE;
                    end else if (code_changed) begin
                        cand <= code_in;
                    end else if (timer_hit) begin
                        state      <= HELD;
                        code_out   <= cand;
                        code_valid <= 1'b1;
                        key_held   <= 1'b1;
`ifdef KEY_DEBOUNCER_REPEAT_EN
                        repeated   <= 1'b0;
`endif
                    end
                end
                HELD: begin
                    if (!key_pressed) begin
                        state <= DEB_RELEASE;
                    end
`ifdef KEY_DEBOUNCER_REPEAT_EN
                    else if (timer_hit) begin
                        code_valid <= 1'b1;
                        repeated   <= 1'b1;
                    end
`endif
                end
                DEB_RELEASE: begin
                    if (key_pressed) begin
                        state    <= HELD;
`ifdef KEY_DEBOUNCER_REPEAT_EN
                        repeated <= 1'b0;
`endif
                    end else if (timer_hit) begin
                        state        <= IDLE;
                        key_held     <= 1'b0;
                        key_released <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

endmodule
